// File: rtl/fix_pkg.sv
// Shared fixed-point constants and helpers for the multiplier scheduler.
// Optional saturation is selected with the FIX_MUL_SAT_EN macro.
package fix_pkg;

    localparam int WS_DEF = 16;
    localparam int DP_DEF = 8;
    localparam int IW_DEF = WS_DEF - DP_DEF;

    localparam logic [WS_DEF-1:0] FIX_MAX = {1'b0, {(WS_DEF-1){1'b1}}};
    localparam logic [WS_DEF-1:0] FIX_MIN = {1'b1, {(WS_DEF-1){1'b0}}};

    // Requester tag width; at least one bit so a two-entry tag still exists.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fix_mul_pipe.sv
// LAT-stage signed Q-format multiply with valid/tag sideband, no arbitration.
// FIX_MUL_SAT_EN: clamp out-of-range products instead of wrapping.
module fix_mul_pipe
    import fix_pkg::*;
#(
    parameter int WS  = WS_DEF,
    parameter int DP  = DP_DEF,
    parameter int LAT = 2,
    parameter int TW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    input  logic [WS-1:0] in_a,
    input  logic [WS-1:0] in_b,
    output logic          out_valid,
    output logic [TW-1:0] out_tag,
    output logic [WS-1:0] out_data,
    output logic [LAT-1:0] stage_valid
);

    logic signed [2*WS-1:0] a_x, b_x, prod;
    logic [WS-1:0]          res;
    logic                   unused_bits;

    logic [LAT-1:0]         vld_q, vld_d;
    logic [LAT-1:0][TW-1:0] tag_q, tag_d;
    logic [LAT-1:0][WS-1:0] dat_q, dat_d;

`ifdef FIX_MUL_SAT_EN
    localparam logic [WS-1:0] SAT_MAX = {1'b0, {(WS-1){1'b1}}};
    localparam logic [WS-1:0] SAT_MIN = {1'b1, {(WS-1){1'b0}}};
`endif

    // Taking bits [WS+DP-1:DP] of the full product is the arithmetic shift
    // by DP (floor toward -inf) followed by wrap to WS bits.
    always_comb begin
        a_x  = {{WS{in_a[WS-1]}}, in_a};
        b_x  = {{WS{in_b[WS-1]}}, in_b};
        prod = a_x * b_x;
        res  = prod[WS+DP-1:DP];
`ifdef FIX_MUL_SAT_EN
        if (!((&prod[2*WS-1:WS+DP-1]) || !(|prod[2*WS-1:WS+DP-1])))
            res = prod[2*WS-1] ? SAT_MIN : SAT_MAX;
`endif
    end

    assign unused_bits = ^{prod[2*WS-1:WS+DP], prod[DP-1:0]};

    // Data registers only load behind a valid so the output holds the last result.
    always_comb begin
        vld_d[0] = in_valid;
        tag_d[0] = in_tag;
        dat_d[0] = in_valid ? res : dat_q[0];
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            dat_q <= dat_d;
        end
    end

    assign out_valid   = vld_q[LAT-1];
    assign out_tag     = tag_q[LAT-1];
    assign out_data    = dat_q[LAT-1];
    assign stage_valid = vld_q;

endmodule

// File: rtl/fix_mul_sched.sv
// Round-robin scheduler sharing one pipelined fixed-point multiplier.
// FIX_MUL_SAT_EN (in fix_mul_pipe) selects saturating instead of wrapping output.
module fix_mul_sched
    import fix_pkg::*;
#(
    parameter int WS   = WS_DEF,
    parameter int DP   = DP_DEF,
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*WS-1:0] req_a,
    input  logic [NREQ*WS-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    res_valid,
    output logic [WS-1:0]      res_data,
    output logic               busy
);

    localparam int TW = tag_w(NREQ);

    logic [TW-1:0]   ptr_q, ptr_d, gidx, idx;
    logic [NREQ-1:0] grant;
    logic            found, accept;
    logic [WS-1:0]   a_sel, b_sel;
    logic            out_valid;
    logic [TW-1:0]   out_tag;
    logic [LAT-1:0]  stage_valid;

    // First valid requester at or after ptr, wrapping at NREQ-1.
    always_comb begin : arb
        int p;
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int k = 0; k < NREQ; k++) begin
            p = int'(ptr_q) + k;
            if (p >= NREQ) p = p - NREQ;
            idx = TW'(p);
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                gidx      = idx;
                grant[idx] = 1'b1;
            end
        end
        req_ready = rst ? '0 : grant;
        accept    = found && !rst;
        ptr_d     = ptr_q;
        if (accept)
            ptr_d = (gidx == TW'(NREQ-1)) ? '0 : gidx + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign a_sel = req_a[int'(gidx)*WS +: WS];
    assign b_sel = req_b[int'(gidx)*WS +: WS];

    fix_mul_pipe #(
        .WS (WS),
        .DP (DP),
        .LAT(LAT),
        .TW (TW)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (accept),
        .in_tag     (gidx),
        .in_a       (a_sel),
        .in_b       (b_sel),
        .out_valid  (out_valid),
        .out_tag    (out_tag),
        .out_data   (res_data),
        .stage_valid(stage_valid)
    );

    always_comb begin
        res_valid = '0;
        if (out_valid) res_valid[out_tag] = 1'b1;
    end

    assign busy = |stage_valid;

endmodule

// File: tb/tb_fix_mul_sched.sv
// Directed self-checking bench for fix_mul_sched (NREQ=4, LAT=2, Q8.8).
module tb_fix_mul_sched;

    localparam int WS = 16, DP = 8, NREQ = 4, LAT = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*WS-1:0] req_a = '0;
    logic [NREQ*WS-1:0] req_b = '0;
    logic [NREQ-1:0]    req_ready, res_valid;
    logic [WS-1:0]      res_data;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    fix_mul_sched #(.WS(WS), .DP(DP), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic clr_req();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*WS +: WS]  = a;
        req_b[i*WS +: WS]  = b;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_req(0, 16'h0100, 16'h0100);
        set_req(2, 16'h0100, 16'h0100);
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_tests++; if (res_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0000", res_valid); end
        n_tests++; if (res_data !== 16'h0000) begin n_fail++; $display("FAIL reset_res_data: got %h want 0000", res_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        rst = 1'b0;
        clr_req();
        set_req(1, 16'h0180, 16'h0200);
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        clr_req();
        @(negedge clk);
        n_tests++; if (res_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early: got %b want 0000", res_valid); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (res_valid !== 4'b0010) begin n_fail++; $display("FAIL single_res_valid: got %b want 0010", res_valid); end
        n_tests++; if (res_data !== 16'h0300) begin n_fail++; $display("FAIL single_res_data: got %h want 0300", res_data); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (res_valid !== 4'b0000) begin n_fail++; $display("FAIL single_one_shot: got %b want 0000", res_valid); end
        n_tests++; if (res_data !== 16'h0300) begin n_fail++; $display("FAIL single_hold: got %h want 0300", res_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_arith();
        logic [15:0] va [7] = '{16'hFF00, 16'hFF00, 16'h7F00, 16'h8000, 16'h8000, 16'hFFFF, 16'h0180};
        logic [15:0] vb [7] = '{16'h0080, 16'hFF00, 16'h0200, 16'h0200, 16'h8000, 16'h0001, 16'h0200};
`ifdef FIX_MUL_SAT_EN
        logic [15:0] ve [7] = '{16'hFF80, 16'h0100, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0300};
`else
        logic [15:0] ve [7] = '{16'hFF80, 16'h0100, 16'hFE00, 16'h0000, 16'h0000, 16'hFFFF, 16'h0300};
`endif
        for (int k = 0; k < 7 + LAT; k++) begin
            @(posedge clk); #1;
            clr_req();
            if (k < 7) set_req(0, va[k], vb[k]);
            @(negedge clk);
            if (k < 7) begin
                n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL arith_ready[%0d]: got %b want 0001", k, req_ready); end
            end
            if (k >= LAT) begin
                n_tests++; if (res_valid !== 4'b0001) begin n_fail++; $display("FAIL arith_valid[%0d]: got %b want 0001", k-LAT, res_valid); end
                n_tests++; if (res_data !== ve[k-LAT]) begin n_fail++; $display("FAIL arith_data[%0d]: got %h want %h", k-LAT, res_data, ve[k-LAT]); end
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_v;
        logic [15:0] exp_d;
        @(posedge clk); #1;
        rst = 1'b1;
        clr_req();
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            clr_req();
            if (k < 8)
                for (int i = 0; i < NREQ; i++) set_req(i, 16'(16'h0100 * (i + 1)), 16'h0100);
            @(negedge clk);
            if (k < 8) begin
                exp_v = 4'b0001 << (k % 4);
                n_tests++; if (req_ready !== exp_v) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, exp_v); end
            end
            if (k >= LAT && k < 8 + LAT) begin
                exp_v = 4'b0001 << ((k - LAT) % 4);
                exp_d = 16'(16'h0100 * (((k - LAT) % 4) + 1));
                n_tests++; if (res_valid !== exp_v) begin n_fail++; $display("FAIL fair_res_valid[%0d]: got %b want %b", k, res_valid, exp_v); end
                n_tests++; if (res_data !== exp_d) begin n_fail++; $display("FAIL fair_res_data[%0d]: got %h want %h", k, res_data, exp_d); end
            end else if (k == 10) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_drain_busy: got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_sparse();
        logic [3:0]  rv [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0001, 4'b1000, 4'b0000};
        logic [15:0] rd [7] = '{16'h0000, 16'h0000, 16'h0011, 16'h0033, 16'h0044, 16'h0055, 16'h0055};
        logic [3:0]  gr [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b1000};
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            case (c)
                0: begin clr_req(); set_req(1, 16'h0011, 16'h0100); end
                1: begin clr_req(); set_req(0, 16'h0044, 16'h0100); set_req(3, 16'h0033, 16'h0100); end
                2: set_req(3, 16'h0055, 16'h0100);
                3: begin clr_req(); set_req(3, 16'h0055, 16'h0100); end
                default: clr_req();
            endcase
            @(negedge clk);
            if (c < 4) begin
                n_tests++; if (req_ready !== gr[c]) begin n_fail++; $display("FAIL sparse_grant[%0d]: got %b want %b", c, req_ready, gr[c]); end
            end
            if (c >= 2) begin
                n_tests++; if (res_valid !== rv[c]) begin n_fail++; $display("FAIL sparse_res_valid[%0d]: got %b want %b", c, res_valid, rv[c]); end
                n_tests++; if (res_data !== rd[c]) begin n_fail++; $display("FAIL sparse_res_data[%0d]: got %h want %h", c, res_data, rd[c]); end
            end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sparse_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        clr_req(); set_req(0, 16'h0200, 16'h0200);
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant_a: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        clr_req(); set_req(1, 16'h0200, 16'h0300);
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_grant_b: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        clr_req();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'h0300, 16'h0100);
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (res_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_flushed: got %b want 0000", res_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_tests++; if (res_data !== 16'h0000) begin n_fail++; $display("FAIL mid_res_data: got %h want 0000", res_data); end
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_zero: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        clr_req();
        @(negedge clk);
        n_tests++; if (res_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_no_late: got %b want 0000", res_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (res_valid !== 4'b0001) begin n_fail++; $display("FAIL mid_after_valid: got %b want 0001", res_valid); end
        n_tests++; if (res_data !== 16'h0300) begin n_fail++; $display("FAIL mid_after_data: got %h want 0300", res_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arith();
        test_fairness();
        test_sparse();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fix_mul_sched.md
Name: fix_mul_sched

Overview:
- Time-shares one pipelined signed fixed-point multiplier between NREQ requesters, e.g. per-channel gain, envelope and filter-coefficient stages of the audio effector.
- Round-robin arbitration, valid/ready request handshake, one multiply accepted per cycle.
- Results return after a fixed latency on a shared data bus, with a one-hot valid naming the owner.

Parameters:
- WS, 16, fixed-point word width in bits.
- DP, 8, fractional bits (Q(WS-DP).DP, two's complement).
- NREQ, 4, number of requesters (2..8).
- LAT, 2, multiplier pipeline depth in cycles (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*WS  operand A, requester i at bits [i*WS +: WS].
- req_b  in  NREQ*WS  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- res_valid  out  NREQ  one-hot, marks the result owner for one cycle.
- res_data  out  WS  product in Q(WS-DP).DP.
- busy  out  1  high while any multiply is in flight.

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous and active-high.
  - Round-robin pointer = 0; all pipeline valid/tag bits cleared.
  - res_valid = 0, res_data = 0, busy = 0.
  - req_ready is combinational but forced to 0 while rst is high.
- Arbitration:
  - Search req_valid starting at index ptr, ascending with wrap at NREQ-1 to 0.
  - The first set bit gets req_ready; all others get 0.
  - No valid request: req_ready = 0, ptr unchanged.
  - On transfer, ptr <= granted+1 (mod NREQ), so the last-served requester gets lowest priority.
- Requester rules:
  - Hold req_valid, req_a and req_b stable until accepted.
  - Dropping valid before the grant is allowed; the request is simply withdrawn.
- Throughput and latency:
  - One accept per cycle, no stalls.
  - An accept in cycle t gives res_valid[owner] = 1 and res_data in cycle t+LAT, for exactly one cycle.
  - The result path has no backpressure; the owner must capture it.
- Pipeline state: a valid bit and a $clog2(NREQ) tag travel with each operand pair through LAT stages.
- busy = OR of all stage valid bits.
- res_data holds its last value when res_valid = 0.
- Arithmetic:
  - Sign-extend A and B to 2*WS and form the signed 2*WS product.
  - Arithmetic shift right by DP (truncation toward -inf, no rounding).
  - Output the low WS bits (wrap on overflow).
- Boundary cases:
  - A requester may re-request in the cycle after its accept; it wins only if no other valid requester lies between ptr and it.
  - All NREQ valid continuously: grants cycle 0,1,..,NREQ-1,0 with no gaps.
  - Reset mid-operation: in-flight products are discarded, no res_valid after reset deasserts, ptr returns to 0.
  - Operands -2^(WS-1) times -2^(WS-1) follow the wrap/saturation rule below.

Optional Feature:
- FIX_MUL_SAT_EN
- Defined: after the shift, a product outside the signed WS range clamps to 0x7FFF (positive) or 0x8000 (negative) for WS=16, i.e. 2^(WS-1)-1 / -2^(WS-1).
- Undefined: plain truncation to the low WS bits (wrap).
- Latency is unchanged either way.

Decomposition:
- Shared package fix_pkg:
  - WS/DP defaults and the derived integer width WS-DP.
  - Q-format saturation limits FIX_MAX and FIX_MIN.
  - A function for requester-tag width.
- Sub-module fix_mul_pipe:
  - LAT-stage signed multiply/shift/(saturate) datapath.
  - Carries a valid bit and tag sideband alongside the data.
  - Contains no arbitration.
- fix_mul_sched holds the arbiter, pointer and busy logic.

Test Plan:
- Single request: requester 1 with 0x0180 * 0x0200 (1.5*2.0) accepted at t gives res_valid = 4'b0010 and res_data = 0x0300 at t+2.
- Sign handling: 0xFF00 * 0x0080 (-1.0*0.5) gives 0xFF80; 0xFF00 * 0xFF00 gives 0x0100.
- Overflow: 0x7F00 * 0x0200 gives 0xFE00 without FIX_MUL_SAT_EN and 0x7FFF with it; 0x8000 * 0x0200 gives 0x0000 without, 0x8000 with.
- Fairness: all four req_valid held high for 8 cycles gives grants 0,1,2,3,0,1,2,3, results in the same order, LAT cycles later, back-to-back.
- Sparse requests with ptr = 2: requesters 0 and 3 both valid, so 3 is granted first, then 0 in the next cycle.
- Reset mid-flight: accept two requests, assert rst one cycle later, then deassert. No res_valid appears, busy = 0, and the next grant with all valid goes to requester 0.
